// File: rtl/freq_pkg.sv
// Shared definitions for the frequency counter and its BCD consumer.
package freq_pkg;

  // Accumulator width and saturation point; three BCD digits downstream.
  localparam int unsigned COUNT_W_DEF   = 10;
  localparam int unsigned MAX_COUNT_DEF = 999;

  // Gate FSM states.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous input, followed by a delay flop
// to produce a single-cycle pulse on each synchronized rising edge.
module sync_edge_detect
  import freq_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic edge_pulse
);

  logic s1_q, s2_q, s3_q;

  // Synchronizer stages plus the delay stage used for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= async_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign edge_pulse = s2_q & ~s3_q;

endmodule

// File: rtl/freq_gate_counter.sv
// Gated edge counter: counts synchronized rising edges of sig_in over a
// window of GATE_CYCLES clocks and publishes a saturated count per window.
module freq_gate_counter
  import freq_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned GATE_CYCLES = CLK_HZ,
  parameter int unsigned COUNT_W     = COUNT_W_DEF,
  parameter int unsigned MAX_COUNT   = MAX_COUNT_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               sig_in,
  output logic [COUNT_W-1:0] freq_count,
  output logic               overflow,
  output logic               count_valid,
  output logic               gate_active
);

  localparam int unsigned          TIMER_W    = $clog2(GATE_CYCLES);
  localparam logic [TIMER_W-1:0]   TIMER_LAST = TIMER_W'(GATE_CYCLES - 1);
  localparam logic [COUNT_W-1:0]   ACC_MAX    = COUNT_W'(MAX_COUNT);

  state_t               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [COUNT_W-1:0]   acc_q, acc_d;
  logic                 ovf_q, ovf_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic                 valid_q, valid_d;
  logic                 edge_w;
  logic [COUNT_W-1:0]   acc_sum;
  logic                 hit_max;

  sync_edge_detect u_sync (
    .clk        (clk),
    .reset      (reset),
    .async_in   (sig_in),
    .edge_pulse (edge_w)
  );

  // Gate FSM, window timer, saturating accumulator and output latch.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    acc_d      = acc_q;
    ovf_d      = ovf_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    valid_d    = 1'b0;

    // Accumulate this cycle's edge without wrapping past MAX_COUNT.
    hit_max = edge_w && (acc_q == ACC_MAX);
    acc_sum = (edge_w && (acc_q != ACC_MAX)) ? acc_q + COUNT_W'(1) : acc_q;

    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        acc_d   = '0;
        ovf_d   = 1'b0;
        if (en) begin
          state_d = ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (!en) begin
          // Abandoning the window: partial count is dropped, outputs hold.
          state_d = ST_IDLE;
          timer_d = '0;
          acc_d   = '0;
          ovf_d   = 1'b0;
        end else if (timer_q == TIMER_LAST) begin
          // Terminal edge closes the window and the next one starts at once.
          count_d    = acc_sum;
          overflow_d = ovf_q | hit_max;
          valid_d    = 1'b1;
          timer_d    = '0;
          acc_d      = '0;
          ovf_d      = 1'b0;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
          acc_d   = acc_sum;
          ovf_d   = ovf_q | hit_max;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      valid_q    <= valid_d;
    end
  end

  assign freq_count  = count_q;
  assign overflow    = overflow_q;
  assign count_valid = valid_q;
  assign gate_active = (state_q == ST_COUNT);

endmodule

// File: tb/tb_freq_gate_counter.sv
// Directed bench for freq_gate_counter: a short-gate instance (100 clk)
// and a long-gate instance (2100 clk) for saturation.
module tb_freq_gate_counter;

  localparam int unsigned CW = 10;

  typedef struct {
    int unsigned cnt;
    logic        ovf;
    int unsigned at;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          en_a, sig_a, ovf_a, val_a, gate_a;
  logic          en_b, sig_b, ovf_b, val_b, gate_b;
  logic [CW-1:0] cnt_a, cnt_b;

  exp_t          qa[$];
  exp_t          qb[$];
  int unsigned   cyc, total, passed, n;
  int            per_a, ph_a, per_b, ph_b;

  always #5 clk = ~clk;

  freq_gate_counter #(
    .GATE_CYCLES (100),
    .COUNT_W     (CW),
    .MAX_COUNT   (999)
  ) dut_a (
    .clk         (clk),
    .reset       (reset),
    .en          (en_a),
    .sig_in      (sig_a),
    .freq_count  (cnt_a),
    .overflow    (ovf_a),
    .count_valid (val_a),
    .gate_active (gate_a)
  );

  freq_gate_counter #(
    .GATE_CYCLES (2100),
    .COUNT_W     (CW),
    .MAX_COUNT   (999)
  ) dut_b (
    .clk         (clk),
    .reset       (reset),
    .en          (en_b),
    .sig_in      (sig_b),
    .freq_count  (cnt_b),
    .overflow    (ovf_b),
    .count_valid (val_b),
    .gate_active (gate_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic push_a(input int unsigned c, input logic o, input int unsigned at);
    exp_t e;
    e.cnt = c; e.ovf = o; e.at = at;
    qa.push_back(e);
  endtask

  task automatic push_b(input int unsigned c, input logic o, input int unsigned at);
    exp_t e;
    e.cnt = c; e.ovf = o; e.at = at;
    qb.push_back(e);
  endtask

  // One clock: sample outputs just after the edge, score strobes, advance generators.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (val_a) begin
      chk("a_strobe_expected", 32'(qa.size() != 0), 1);
      if (qa.size() != 0) begin
        e = qa.pop_front();
        chk("a_count", 32'(cnt_a), e.cnt);
        chk("a_overflow", 32'(ovf_a), 32'(e.ovf));
        chk("a_strobe_cycle", cyc, e.at);
      end
    end
    if (val_b) begin
      chk("b_strobe_expected", 32'(qb.size() != 0), 1);
      if (qb.size() != 0) begin
        e = qb.pop_front();
        chk("b_count", 32'(cnt_b), e.cnt);
        chk("b_overflow", 32'(ovf_b), 32'(e.ovf));
        chk("b_strobe_cycle", cyc, e.at);
      end
    end
    if (per_a > 0) begin
      sig_a = (ph_a < per_a / 2);
      ph_a  = (ph_a + 1) % per_a;
    end
    if (per_b > 0) begin
      sig_b = (ph_b < per_b / 2);
      ph_b  = (ph_b + 1) % per_b;
    end
  endtask

  task automatic ticks(input int unsigned k);
    for (int unsigned i = 0; i < k; i++) tick();
  endtask

  initial begin
    reset = 1'b1; en_a = 1'b0; en_b = 1'b0; sig_a = 1'b0; sig_b = 1'b0;
    per_a = 0; ph_a = 0; per_b = 0; ph_b = 0;
    cyc = 0; total = 0; passed = 0;

    ticks(4);
    chk("rst_cnt_a",  32'(cnt_a), 0);
    chk("rst_ovf_a",  32'(ovf_a), 0);
    chk("rst_val_a",  32'(val_a), 0);
    chk("rst_gate_a", 32'(gate_a), 0);
    chk("rst_cnt_b",  32'(cnt_b), 0);
    chk("rst_gate_b", 32'(gate_b), 0);
    reset = 1'b0;
    ticks(2);

    // Period-10 input, three back-to-back windows.
    en_a = 1'b1; per_a = 10; ph_a = 0; n = cyc;
    for (int unsigned k = 1; k <= 3; k++) push_a(10, 1'b0, n + 100 * k + 1);
    ticks(350);
    chk("t1_gate_active", 32'(gate_a), 1);

    // Drop en mid-window: no strobe, outputs hold; re-raise restarts timing.
    en_a = 1'b0;
    ticks(200);
    chk("t4_hold_cnt",  32'(cnt_a), 10);
    chk("t4_hold_ovf",  32'(ovf_a), 0);
    chk("t4_gate_idle", 32'(gate_a), 0);
    en_a = 1'b1; n = cyc;
    push_a(10, 1'b0, n + 101);
    ticks(160);

    // Reset mid-window with en held.
    reset = 1'b1; per_a = 0; sig_a = 1'b0;
    ticks(1);
    reset = 1'b0;
    chk("t5_rst_cnt",  32'(cnt_a), 0);
    chk("t5_rst_ovf",  32'(ovf_a), 0);
    chk("t5_rst_val",  32'(val_a), 0);
    chk("t5_rst_gate", 32'(gate_a), 0);
    n = cyc; per_a = 10; ph_a = 0;
    push_a(10, 1'b0, n + 101);
    ticks(105);

    // Input held low, then held high after a single rise.
    en_a = 1'b0; per_a = 0; sig_a = 1'b0;
    ticks(5);
    en_a = 1'b1; n = cyc;
    push_a(0, 1'b0, n + 101);
    push_a(0, 1'b0, n + 201);
    ticks(50);
    chk("t3_gate_active", 32'(gate_a), 1);
    ticks(155);
    en_a = 1'b0; sig_a = 1'b1;
    ticks(5);
    en_a = 1'b1; n = cyc;
    push_a(0, 1'b0, n + 101);
    push_a(0, 1'b0, n + 201);
    ticks(205);

    // Single edge landing in the terminal cycle, then in the first cycle.
    en_a = 1'b0; sig_a = 1'b0;
    ticks(5);
    en_a = 1'b1; n = cyc;
    push_a(1, 1'b0, n + 101);
    push_a(0, 1'b0, n + 201);
    ticks(98);
    sig_a = 1'b1;
    ticks(110);
    en_a = 1'b0; sig_a = 1'b0;
    ticks(5);
    en_a = 1'b1; n = cyc;
    push_a(0, 1'b0, n + 101);
    push_a(1, 1'b0, n + 201);
    ticks(99);
    sig_a = 1'b1;
    ticks(110);
    en_a = 1'b0;
    ticks(3);

    // Long gate: saturation with period 2, then recovery with period 10.
    per_b = 2; ph_b = 0;
    ticks(10);
    en_b = 1'b1; n = cyc;
    push_b(999, 1'b1, n + 2101);
    ticks(2105);
    en_b = 1'b0; per_b = 10; ph_b = 0;
    ticks(20);
    chk("t2_hold_cnt", 32'(cnt_b), 999);
    chk("t2_hold_ovf", 32'(ovf_b), 1);
    en_b = 1'b1; n = cyc;
    push_b(210, 1'b0, n + 2101);
    ticks(2105);
    en_b = 1'b0;
    ticks(3);

    chk("a_pending_strobes", 32'(qa.size()), 0);
    chk("b_pending_strobes", 32'(qb.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
